pipe_control: RTL and testbench

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_control.sv | 227 ++++++++++++++++++++++
 tb/tb_pipe_control.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// Pipeline controller: registered instruction decode plus a RUN/STALL/FLUSH
// sequencer handling load-use stalls and branch/jump flushes.
module pipe_control #(
    parameter int RADDR_W     = 4,
    parameter int FLUSH_DEPTH = 3,
    parameter int LU_STALL    = 1,
    parameter int LINK_REG    = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               br_taken,
    output logic               flush,
    output logic [RADDR_W-1:0] addr_rs,
    output logic [RADDR_W-1:0] addr_rt,
    output logic [RADDR_W-1:0] addr_rd,
    output logic [RADDR_W-1:0] wb_waddr,
    output logic               wb_wr,
    output logic               ram_rd,
    output logic               ram_wr,
    output logic [2:0]         alu_cmd,
    output logic [5:0]         immediate,
    output logic [2:0]         shamt,
    output logic               op2_sel,
    output logic               shamt_imm_sel,
    output logic               res_sel,
    output logic               beq_sel,
    output logic               jump_sel,
    output logic               wb_sel,
    output logic               save_pc_sel,
    output logic [1:0]         state_o
);

    localparam int CNT_MAX = (FLUSH_DEPTH > LU_STALL) ? FLUSH_DEPTH : LU_STALL;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_STALL = 2'b01,
        S_FLUSH = 2'b10
    } state_e;

    typedef struct packed {
        logic               wb_wr;
        logic [RADDR_W-1:0] wb_waddr;
        logic               ram_rd;
        logic               ram_wr;
        logic [2:0]         alu_cmd;
        logic [5:0]         immediate;
        logic [2:0]         shamt;
        logic               op2_sel;
        logic               shamt_imm_sel;
        logic               res_sel;
        logic               beq_sel;
        logic               jump_sel;
        logic               wb_sel;
        logic               save_pc_sel;
    } ctrl_t;

    function automatic ctrl_t bubble();
        ctrl_t c;
        c         = '0;
        c.res_sel = 1'b1;
        c.beq_sel = 1'b1;
        return c;
    endfunction

    // beq_sel is low only for beq; shamt comes from the rt field for shifts
    function automatic ctrl_t decode(input logic [15:0] ins);
        ctrl_t c;
        c = bubble();
        if (ins != 16'h0000) begin
            case (ins[15:12])
                4'd0: begin
                    c.wb_wr    = 1'b1;
                    c.wb_waddr = RADDR_W'(ins[5:3]);
                    case (ins[2:0])
                        3'd0: c.alu_cmd = 3'b000;
                        3'd1: c.alu_cmd = 3'b001;
                        3'd2: c.alu_cmd = 3'b101;
                        3'd3: c.alu_cmd = 3'b110;
                        3'd4: c.alu_cmd = 3'b011;
                        3'd5: begin c.alu_cmd = 3'b010; c.shamt_imm_sel = 1'b1; end
                        3'd6: begin c.alu_cmd = 3'b100; c.shamt_imm_sel = 1'b1; end
                        default: begin
                            c.wb_wr    = 1'b0;
                            c.wb_waddr = '0;
                            c.jump_sel = 1'b1;
                        end
                    endcase
                end
                4'd1, 4'd3: begin
                    c.wb_wr    = 1'b1;
                    c.wb_waddr = RADDR_W'(ins[8:6]);
                    c.wb_sel   = 1'b1;
                    c.op2_sel  = 1'b1;
                    c.alu_cmd  = (ins[15:12] == 4'd3) ? 3'b011 : 3'b000;
                end
                4'd4: begin
                    c.wb_wr    = 1'b1;
                    c.wb_waddr = RADDR_W'(ins[8:6]);
                    c.wb_sel   = 1'b1;
                    c.op2_sel  = 1'b1;
                    c.res_sel  = 1'b0;
                    c.ram_rd   = 1'b1;
                end
                4'd5: begin
                    c.ram_wr  = 1'b1;
                    c.op2_sel = 1'b1;
                end
                4'd6: begin
                    c.alu_cmd = 3'b111;
                    c.beq_sel = 1'b0;
                end
                4'd7: begin
                    c.jump_sel = 1'b1;
                    c.op2_sel  = 1'b1;
                end
                4'd8: begin
                    c.wb_wr       = 1'b1;
                    c.wb_waddr    = RADDR_W'(LINK_REG);
                    c.save_pc_sel = 1'b1;
                    c.jump_sel    = 1'b1;
                    c.op2_sel     = 1'b1;
                end
                default: c = bubble();
            endcase
            if (c != bubble()) begin
                c.immediate = ins[5:0];
                c.shamt     = ins[8:6];
            end
        end
        return c;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      hold_q, hold_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             hazard;

    assign addr_rs = RADDR_W'(instr[11:9]);
    assign addr_rt = RADDR_W'(instr[8:6]);
    assign addr_rd = RADDR_W'(instr[5:3]);

    // The registered outputs are the last issued instruction, so they double as load tracking
    assign hazard = instr_valid && ctrl_q.ram_rd && (ctrl_q.wb_waddr != '0) &&
                    ((ctrl_q.wb_waddr == addr_rs) || (ctrl_q.wb_waddr == addr_rt));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        ctrl_d      = bubble();
        instr_ready = 1'b0;
        flush       = (state_q == S_FLUSH);
        case (state_q)
            S_RUN: begin
                instr_ready = rst;
                if (br_taken) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_DEPTH);
                end else if (hazard) begin
                    // The hazard cycle itself issues the first bubble
                    state_d = S_STALL;
                    cnt_d   = CNT_W'(LU_STALL - 1);
                    hold_d  = instr;
                end else if (instr_valid) begin
                    ctrl_d = decode(instr);
                end
            end
            S_STALL: begin
                if (br_taken) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_DEPTH);
                end else if (cnt_q == '0) begin
                    state_d = S_RUN;
                    ctrl_d  = decode(hold_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (br_taken) begin
                    cnt_d = CNT_W'(FLUSH_DEPTH);
                end else begin
                    cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
                    if (cnt_q <= CNT_W'(1)) state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            hold_q  <= '0;
            ctrl_q  <= bubble();
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign wb_waddr      = ctrl_q.wb_waddr;
    assign wb_wr         = ctrl_q.wb_wr;
    assign ram_rd        = ctrl_q.ram_rd;
    assign ram_wr        = ctrl_q.ram_wr;
    assign alu_cmd       = ctrl_q.alu_cmd;
    assign immediate     = ctrl_q.immediate;
    assign shamt         = ctrl_q.shamt;
    assign op2_sel       = ctrl_q.op2_sel;
    assign shamt_imm_sel = ctrl_q.shamt_imm_sel;
    assign res_sel       = ctrl_q.res_sel;
    assign beq_sel       = ctrl_q.beq_sel;
    assign jump_sel      = ctrl_q.jump_sel;
    assign wb_sel        = ctrl_q.wb_sel;
    assign save_pc_sel   = ctrl_q.save_pc_sel;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: each cycle's expected registered outputs
// are queued with the stimulus and compared one cycle later.
module tb_pipe_control;

    typedef struct packed {
        logic       wb_wr;
        logic [3:0] wb_waddr;
        logic       ram_rd;
        logic       ram_wr;
        logic [2:0] alu_cmd;
        logic [5:0] immediate;
        logic [2:0] shamt;
        logic       op2_sel;
        logic       shamt_imm_sel;
        logic       res_sel;
        logic       beq_sel;
        logic       jump_sel;
        logic       wb_sel;
        logic       save_pc_sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid, instr_ready, br_taken, flush;
    logic [3:0]  addr_rs, addr_rt, addr_rd, wb_waddr;
    logic        wb_wr, ram_rd, ram_wr;
    logic [2:0]  alu_cmd, shamt;
    logic [5:0]  immediate;
    logic        op2_sel, shamt_imm_sel, res_sel, beq_sel, jump_sel, wb_sel, save_pc_sel;
    logic [1:0]  state_o;
    exp_t        got_v;
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;

    pipe_control dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .br_taken(br_taken), .flush(flush),
        .addr_rs(addr_rs), .addr_rt(addr_rt), .addr_rd(addr_rd),
        .wb_waddr(wb_waddr), .wb_wr(wb_wr), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .alu_cmd(alu_cmd), .immediate(immediate), .shamt(shamt),
        .op2_sel(op2_sel), .shamt_imm_sel(shamt_imm_sel), .res_sel(res_sel),
        .beq_sel(beq_sel), .jump_sel(jump_sel), .wb_sel(wb_sel),
        .save_pc_sel(save_pc_sel), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign got_v = {wb_wr, wb_waddr, ram_rd, ram_wr, alu_cmd, immediate, shamt,
                    op2_sel, shamt_imm_sel, res_sel, beq_sel, jump_sel, wb_sel, save_pc_sel};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(logic wb, logic [3:0] wa, logic rd, logic wr, logic [2:0] alu,
                                logic [5:0] imm, logic [2:0] sh, logic op2, logic shi, logic res,
                                logic beq, logic jmp, logic wbs, logic spc);
        exp_t e;
        e.wb_wr = wb; e.wb_waddr = wa; e.ram_rd = rd; e.ram_wr = wr; e.alu_cmd = alu;
        e.immediate = imm; e.shamt = sh; e.op2_sel = op2; e.shamt_imm_sel = shi;
        e.res_sel = res; e.beq_sel = beq; e.jump_sel = jmp; e.wb_sel = wbs; e.save_pc_sel = spc;
        return e;
    endfunction

    // One clock: drive, check combinational handshake, queue expectation, then compare
    task automatic cyc(input logic r, input logic [15:0] i, input logic v, input logic b,
                       input logic er, input logic ef, input logic [1:0] es, input exp_t eo);
        exp_t e;
        rst = r; instr = i; instr_valid = v; br_taken = b;
        #1;
        chk("instr_ready", 32'(instr_ready), 32'(er));
        chk("flush", 32'(flush), 32'(ef));
        chk("state_o", 32'(state_o), 32'(es));
        sb.push_back(eo);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            chk("outputs", 32'(got_v), 32'(e));
        end
    endtask

    exp_t BUB, ADD, SUB, AND_, OR_, SLT, SLL, SRL, ADDI, SLTI, SW, BEQ, J, JAL, JR;
    exp_t LW, ADD2, LW0, ADD3;

    initial begin
        BUB  = mk(0, 0,  0, 0, 3'b000, 6'h00, 0, 0, 0, 1, 1, 0, 0, 0);
        ADD  = mk(1, 3,  0, 0, 3'b000, 6'h18, 2, 0, 0, 1, 1, 0, 0, 0);
        SUB  = mk(1, 3,  0, 0, 3'b001, 6'h19, 2, 0, 0, 1, 1, 0, 0, 0);
        AND_ = mk(1, 3,  0, 0, 3'b101, 6'h1A, 2, 0, 0, 1, 1, 0, 0, 0);
        OR_  = mk(1, 3,  0, 0, 3'b110, 6'h1B, 2, 0, 0, 1, 1, 0, 0, 0);
        SLT  = mk(1, 3,  0, 0, 3'b011, 6'h1C, 2, 0, 0, 1, 1, 0, 0, 0);
        SLL  = mk(1, 3,  0, 0, 3'b010, 6'h1D, 2, 0, 1, 1, 1, 0, 0, 0);
        SRL  = mk(1, 3,  0, 0, 3'b100, 6'h1E, 2, 0, 1, 1, 1, 0, 0, 0);
        JR   = mk(0, 0,  0, 0, 3'b000, 6'h07, 0, 0, 0, 1, 1, 1, 0, 0);
        ADDI = mk(1, 2,  0, 0, 3'b000, 6'h05, 2, 1, 0, 1, 1, 0, 1, 0);
        SLTI = mk(1, 2,  0, 0, 3'b011, 6'h05, 2, 1, 0, 1, 1, 0, 1, 0);
        SW   = mk(0, 0,  0, 1, 3'b000, 6'h05, 2, 1, 0, 1, 1, 0, 0, 0);
        BEQ  = mk(0, 0,  0, 0, 3'b111, 6'h05, 2, 0, 0, 1, 0, 0, 0, 0);
        J    = mk(0, 0,  0, 0, 3'b000, 6'h05, 0, 1, 0, 1, 1, 1, 0, 0);
        JAL  = mk(1, 15, 0, 0, 3'b000, 6'h05, 0, 1, 0, 1, 1, 1, 0, 1);
        LW   = mk(1, 2,  1, 0, 3'b000, 6'h00, 2, 1, 0, 0, 1, 0, 1, 0);
        ADD2 = mk(1, 3,  0, 0, 3'b000, 6'h18, 1, 0, 0, 1, 1, 0, 0, 0);
        LW0  = mk(1, 0,  1, 0, 3'b000, 6'h00, 0, 1, 0, 0, 1, 0, 1, 0);
        ADD3 = mk(1, 3,  0, 0, 3'b000, 6'h18, 0, 0, 0, 1, 1, 0, 0, 0);

        rst = 1'b0; instr = 16'h0298; instr_valid = 1'b1; br_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(instr_ready), 32'(0));
        chk("rst_flush", 32'(flush), 32'(0));
        chk("rst_state", 32'(state_o), 32'(0));
        chk("rst_outputs", 32'(got_v), 32'(BUB));

        // decode of every opcode
        cyc(1, 16'h0298, 1, 0, 1, 0, 2'b00, ADD);
        chk("addr_rs", 32'(addr_rs), 32'(1));
        chk("addr_rt", 32'(addr_rt), 32'(2));
        chk("addr_rd", 32'(addr_rd), 32'(3));
        cyc(1, 16'h0299, 1, 0, 1, 0, 2'b00, SUB);
        cyc(1, 16'h029A, 1, 0, 1, 0, 2'b00, AND_);
        cyc(1, 16'h029B, 1, 0, 1, 0, 2'b00, OR_);
        cyc(1, 16'h029C, 1, 0, 1, 0, 2'b00, SLT);
        cyc(1, 16'h029D, 1, 0, 1, 0, 2'b00, SLL);
        cyc(1, 16'h029E, 1, 0, 1, 0, 2'b00, SRL);
        cyc(1, 16'h0207, 1, 0, 1, 0, 2'b00, JR);
        cyc(1, 16'h1285, 1, 0, 1, 0, 2'b00, ADDI);
        cyc(1, 16'h3285, 1, 0, 1, 0, 2'b00, SLTI);
        cyc(1, 16'h5285, 1, 0, 1, 0, 2'b00, SW);
        cyc(1, 16'h6285, 1, 0, 1, 0, 2'b00, BEQ);
        cyc(1, 16'h7005, 1, 0, 1, 0, 2'b00, J);
        cyc(1, 16'h8005, 1, 0, 1, 0, 2'b00, JAL);
        // nops: undefined opcode, all-zero word, invalid
        cyc(1, 16'h9285, 1, 0, 1, 0, 2'b00, BUB);
        cyc(1, 16'h0000, 1, 0, 1, 0, 2'b00, BUB);
        cyc(1, 16'h0298, 0, 0, 1, 0, 2'b00, BUB);

        // load-use: one bubble, next instruction held off while stalled
        cyc(1, 16'h4280, 1, 0, 1, 0, 2'b00, LW);
        cyc(1, 16'h0458, 1, 0, 1, 0, 2'b00, BUB);
        cyc(1, 16'h1285, 1, 0, 0, 0, 2'b01, ADD2);
        cyc(1, 16'h1285, 1, 0, 1, 0, 2'b00, ADDI);
        // load to r0 never stalls
        cyc(1, 16'h4000, 1, 0, 1, 0, 2'b00, LW0);
        cyc(1, 16'h0018, 1, 0, 1, 0, 2'b00, ADD3);

        // taken branch: exactly FLUSH_DEPTH flush cycles
        cyc(1, 16'h0298, 1, 1, 1, 0, 2'b00, BUB);
        repeat (3) cyc(1, 16'h0298, 1, 0, 0, 1, 2'b10, BUB);
        cyc(1, 16'h0298, 1, 0, 1, 0, 2'b00, ADD);
        // reload during flush
        cyc(1, 16'h0298, 1, 1, 1, 0, 2'b00, BUB);
        cyc(1, 16'h0298, 1, 1, 0, 1, 2'b10, BUB);
        repeat (3) cyc(1, 16'h0298, 1, 0, 0, 1, 2'b10, BUB);
        cyc(1, 16'h0299, 1, 0, 1, 0, 2'b00, SUB);

        // hazard and branch together: flush wins, held add discarded
        cyc(1, 16'h4280, 1, 0, 1, 0, 2'b00, LW);
        cyc(1, 16'h0458, 1, 1, 1, 0, 2'b00, BUB);
        repeat (3) cyc(1, 16'h0000, 0, 0, 0, 1, 2'b10, BUB);
        cyc(1, 16'h0000, 0, 0, 1, 0, 2'b00, BUB);
        cyc(1, 16'h0000, 0, 0, 1, 0, 2'b00, BUB);

        // branch during stall abandons it
        cyc(1, 16'h4280, 1, 0, 1, 0, 2'b00, LW);
        cyc(1, 16'h0458, 1, 0, 1, 0, 2'b00, BUB);
        cyc(1, 16'h0000, 0, 1, 0, 0, 2'b01, BUB);
        repeat (3) cyc(1, 16'h0000, 0, 0, 0, 1, 2'b10, BUB);
        cyc(1, 16'h0000, 0, 0, 1, 0, 2'b00, BUB);

        // reset in the middle of a flush
        cyc(1, 16'h0298, 1, 1, 1, 0, 2'b00, BUB);
        cyc(1, 16'h0000, 0, 0, 0, 1, 2'b10, BUB);
        cyc(0, 16'h0000, 0, 0, 0, 1, 2'b10, BUB);
        cyc(1, 16'h0298, 1, 0, 1, 0, 2'b00, ADD);
        cyc(1, 16'h0000, 0, 0, 1, 0, 2'b00, BUB);

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
